// File: rtl/logicnet_pkg.sv
// +------------------------------------------------------------------------------+
// | logicnet_pkg: shared types and sizing helpers for the LogicNet LUT layer     |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
`default_nettype none

package logicnet_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } lnl_state_e;

  // Index width that never collapses to zero bits for a single-neuron layer.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int lut_entries(input int in_bits);
    return 1 << in_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lut_neuron_ram.sv
// +------------------------------------------------------------------------------+
// | lut_neuron_ram: one neuron truth table, single write port, async read port   |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
`default_nettype none

module lut_neuron_ram
  import logicnet_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [IN_BITS-1:0]  waddr_i,
  input  logic [OUT_BITS-1:0] wdata_i,
  input  logic [IN_BITS-1:0]  raddr_i,
  output logic [OUT_BITS-1:0] rdata_o
);

  localparam int DEPTH = lut_entries(IN_BITS);

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [OUT_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/logicnet_lut_layer_rt.sv
// +------------------------------------------------------------------------------+
// | logicnet_lut_layer_rt: run-time-loadable LogicNet layer, one registered stage |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
`default_nettype none

module logicnet_lut_layer_rt
  import logicnet_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_we,
  input  logic [clog2_min1(NUM_NEURONS)-1:0]  cfg_neuron,
  input  logic [IN_BITS-1:0]                  cfg_addr,
  input  logic [OUT_BITS-1:0]                 cfg_data,
  output logic                                cfg_ready,
  output logic                                init_done,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]      in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0]     out_data
);

  localparam int NB = clog2_min1(NUM_NEURONS);
  localparam logic [IN_BITS-1:0] CLR_LAST = '1;

  lnl_state_e                       state_q;
  logic [IN_BITS-1:0]               clr_cnt_q;
  logic                             init_done_q;
  logic                             cfg_ready_q;
  logic                             out_valid_q, out_valid_d;
  logic [NUM_NEURONS*OUT_BITS-1:0]  out_data_q, out_data_d;

  logic [NUM_NEURONS-1:0]           ram_we;
  logic [IN_BITS-1:0]               ram_waddr;
  logic [OUT_BITS-1:0]              ram_wdata;
  logic [NUM_NEURONS*OUT_BITS-1:0]  lut_rdata;
  logic                             accept;

  // Config write takes priority over input; an out-of-range neuron index decodes to no enable.
  always_comb begin
    ram_we    = '0;
    ram_waddr = cfg_addr;
    ram_wdata = cfg_data;
    if (state_q == CLEAR) begin
      ram_we    = '1;
      ram_waddr = clr_cnt_q;
      ram_wdata = '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        ram_we[i] = cfg_we && (cfg_neuron == NB'(i));
      end
    end
  end

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_neuron
    lut_neuron_ram #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_ram (
      .clk     (clk),
      .we_i    (ram_we[g]),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (in_data[g*IN_BITS +: IN_BITS]),
      .rdata_o (lut_rdata[g*OUT_BITS +: OUT_BITS])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + IN_BITS'(1);
          if (clr_cnt_q == CLR_LAST) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
            cfg_ready_q <= 1'b1;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= CLEAR;
        end
      endcase
    end
  end

  assign in_ready = (state_q == RUN) && !cfg_we && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lut_rdata;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign init_done = init_done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_logicnet_lut_layer_rt.sv
// +------------------------------------------------------------------------------+
// | tb_logicnet_lut_layer_rt: directed self-checking bench for the LUT layer     |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
`default_nettype none

module tb_logicnet_lut_layer_rt;

  // 12 neurons keep the 4-bit index port able to express out-of-range neurons.
  localparam int N  = 12;
  localparam int IB = 8;
  localparam int OB = 1;
  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_we = 1'b0;
  logic [NB-1:0]   cfg_neuron = '0;
  logic [IB-1:0]   cfg_addr = '0;
  logic [OB-1:0]   cfg_data = '0;
  logic            cfg_ready;
  logic            init_done;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*IB-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N*OB-1:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [255:0] model [N];

  logicnet_lut_layer_rt #(
    .NUM_NEURONS (N),
    .IN_BITS     (IB),
    .OUT_BITS    (OB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .init_done  (init_done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] golden(input logic [N*IB-1:0] d);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = model[i][d[i*IB +: IB]];
    return r;
  endfunction

  function automatic logic [N*IB-1:0] splat(input logic [IB-1:0] a);
    logic [N*IB-1:0] d;
    for (int i = 0; i < N; i++) d[i*IB +: IB] = a;
    return d;
  endfunction

  function automatic logic [N*IB-1:0] rand_vec();
    logic [N*IB-1:0] d;
    for (int i = 0; i < N; i++) d[i*IB +: IB] = IB'($urandom_range(0, 255));
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    int  n;
    bit  early;
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({out_valid, init_done, cfg_ready, in_ready} !== 4'b0000 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%b r=%b i=%b data=%h, need all 0",
               out_valid, init_done, cfg_ready, in_ready, out_data);
    end
    // Writes and inputs offered during CLEAR must be ignored.
    rst = 1'b0; cfg_we = 1'b1; cfg_neuron = 4'd3; cfg_addr = 8'h20; cfg_data = 1'b1;
    in_valid = 1'b1; in_data = splat(8'h20);
    n = 0; early = 1'b0;
    while (!init_done && n < 300) begin
      if (in_ready || cfg_ready || out_valid) early = 1'b1;
      tick();
      n++;
    end
    cfg_we = 1'b0;
    clear_model();
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL init_latency: got %0d cycles, need 256", n);
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL ready_during_clear: got ready/valid high before init_done, need 0");
    end
    #1;
    checks++;
    if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_init: got in_ready=%b cfg_ready=%b, need 1 1", in_ready, cfg_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL cleared_lookup: got v=%b data=%h, need v=1 data=0", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_write_lookup();
    cfg_we = 1'b1; cfg_neuron = 4'd3; cfg_addr = 8'h20; cfg_data = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_ready: got %b, need 1", cfg_ready);
    end
    tick();
    cfg_we = 1'b0;
    model[3][8'h20] = 1'b1;
    in_data = '0; in_data[3*IB +: IB] = 8'h20; in_valid = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 12'h008) begin
      errors++;
      $display("FAIL write_hit: got v=%b data=%h, need v=1 data=008", out_valid, out_data);
    end
    in_data[3*IB +: IB] = 8'h21;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 12'h000) begin
      errors++;
      $display("FAIL write_miss: got v=%b data=%h, need v=1 data=000", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp;
    int           gaps;
    for (int k = 0; k < 400; k++) begin
      cfg_we = 1'b1;
      cfg_neuron = NB'($urandom_range(0, N-1));
      cfg_addr = IB'($urandom_range(0, 255));
      cfg_data = OB'($urandom_range(0, 1));
      tick();
      model[cfg_neuron][cfg_addr] = cfg_data[0];
    end
    cfg_we = 1'b0; out_ready = 1'b1; in_valid = 1'b1; gaps = 0;
    for (int k = 0; k < 100; k++) begin
      in_data = rand_vec();
      exp = golden(in_data);
      #1;
      if (in_ready !== 1'b1) gaps++;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got v=%b data=%h, need v=1 data=%h", k, out_valid, out_data, exp);
      end
    end
    checks++;
    if (gaps !== 0) begin
      errors++;
      $display("FAIL b2b_gaps: got %0d stalled cycles, need 0", gaps);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [N*IB-1:0] a, b;
    logic [N-1:0]    ea, eb;
    a = rand_vec(); ea = golden(a);
    b = rand_vec(); eb = golden(b);
    for (int t = 0; t < 50 && eb == ea; t++) begin
      b = rand_vec(); eb = golden(b);
    end
    if (eb == ea) begin
      b = a; b[0 +: IB] = b[0 +: IB] ^ 8'h01; eb = golden(b);
    end
    in_valid = 1'b1; in_data = a; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_data = b;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready[%0d]: got %b, need 0", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== ea) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b data=%h, need v=1 data=%h", k, out_valid, out_data, ea);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, need 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== eb) begin
      errors++;
      $display("FAIL bp_release_data: got v=%b data=%h, need v=1 data=%h", out_valid, out_data, eb);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got out_valid=%b, need 0", out_valid);
    end
  endtask

  task automatic test_collision();
    logic [IB-1:0] a;
    logic          nv;
    logic [N-1:0]  exp;
    a = IB'($urandom_range(0, 255));
    nv = ~model[5][a];
    in_data = rand_vec(); in_data[5*IB +: IB] = a; in_valid = 1'b1;
    cfg_we = 1'b1; cfg_neuron = 4'd5; cfg_addr = a; cfg_data = nv;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL coll_in_ready: got %b, need 0", in_ready);
    end
    tick();
    cfg_we = 1'b0;
    model[5][a] = nv;
    exp = golden(in_data);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL coll_no_accept: got out_valid=%b, need 0", out_valid);
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL coll_retry_ready: got %b, need 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      errors++;
      $display("FAIL coll_new_value: got v=%b data=%h, need v=1 data=%h", out_valid, out_data, exp);
    end
    in_valid = 1'b0;
    tick();
    for (int n = N; n < 16; n++) begin
      cfg_we = 1'b1; cfg_neuron = NB'(n);
      cfg_addr = IB'($urandom_range(0, 255));
      cfg_data = ~model[n - N][cfg_addr];
      #1;
      checks++;
      if (cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL oob_cfg_ready[%0d]: got %b, need 1", n, cfg_ready);
      end
      tick();
    end
    cfg_we = 1'b0; in_valid = 1'b1;
    for (int a2 = 0; a2 < 256; a2++) begin
      in_data = splat(IB'(a2));
      exp = golden(in_data);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++;
        $display("FAIL oob_sweep[%0d]: got v=%b data=%h, need v=1 data=%h", a2, out_valid, out_data, exp);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid();
    int n;
    for (int i = 0; i < N; i++) begin
      cfg_we = 1'b1; cfg_neuron = NB'(i); cfg_addr = 8'h20; cfg_data = 1'b1;
      tick();
      model[i][8'h20] = 1'b1;
    end
    cfg_we = 1'b0;
    in_valid = 1'b1; in_data = splat(8'h20); out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== {N{1'b1}}) begin
      errors++;
      $display("FAIL pre_rst_lookup: got v=%b data=%h, need v=1 data=fff", out_valid, out_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL async_rst: got v=%b data=%h, need v=0 data=0", out_valid, out_data);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (init_done !== 1'b0 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: got init_done=%b cfg_ready=%b, need 0 0", init_done, cfg_ready);
    end
    rst = 1'b0;
    clear_model();
    n = 0;
    while (!init_done && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL reclear_latency: got %0d cycles, need 256", n);
    end
    in_valid = 1'b1; in_data = splat(8'h20);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL reclear_entry: got v=%b data=%h, need v=1 data=000", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    clear_model();
    test_reset();
    test_write_lookup();
    test_back_to_back();
    test_backpressure();
    test_collision();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
